regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/waddr/wdata) between NREQ writeback sources, e.g. the EX/MEM path, the load unit and the multi-cycle mul/div unit.
- Each source writes into its own 1-entry holding slot through a valid/ready handshake.
- A round-robin arbiter drains one slot per cycle into a registered write port that drives the register file directly.
- The block sits between the pipeline writeback stage and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file widths, writeback requester count and index helpers
package regfile_wb_arbiter_pkg;
  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_BUS_W = 32;
  localparam int WB_REQ_NUM = 3;
  localparam int WB_IDX_W = 3;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  typedef logic [WB_IDX_W-1:0] wb_idx_t;
  // Index k steps after base, wrapping at n.
  function automatic wb_idx_t rr_idx(input wb_idx_t base, input int k, input int n);
    return wb_idx_t'((int'(base) + k) % n);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after ptr, one-hot plus encoded index
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = WB_REQ_NUM
) (
  input  logic [N-1:0] req_i,
  input  wb_idx_t      ptr_i,
  output logic [N-1:0] grant_o,
  output wb_idx_t      idx_o,
  output logic         valid_o
);
  // Scan ptr+1 .. ptr+N; the first requester found wins.
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++)
      for (int i = 0; i < N; i++)
        if (!valid_o && req_i[i] && rr_idx(ptr_i, k, N) == wb_idx_t'(i)) begin
          grant_o[i] = 1'b1;
          idx_o = wb_idx_t'(i);
          valid_o = 1'b1;
        end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges NREQ writeback sources via 1-entry slots onto one registered RF write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WB_REQ_NUM,
  parameter int AW = REG_NUM_LOG2,
  parameter int DW = REG_BUS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*AW-1:0]  req_waddr,
  input  logic [NREQ*DW-1:0]  req_wdata,
  output logic                we,
  output logic [AW-1:0]       waddr,
  output logic [DW-1:0]       wdata,
  output logic [WB_IDX_W-1:0] grant_id,
  output logic                busy
);
  logic [NREQ-1:0] full_q, full_d, grant;
  logic [NREQ-1:0][AW-1:0] addr_q, addr_d;
  logic [NREQ-1:0][DW-1:0] data_q, data_d;
  logic [AW-1:0] waddr_q, sel_addr;
  logic [DW-1:0] wdata_q, sel_data;
  wb_idx_t ptr_q, gid_q, idx;
  logic we_q, any;
  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i  (full_q),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (idx),
    .valid_o(any)
  );
  // A draining slot may refill on the same edge, so each source sustains one write per cycle.
  assign req_ready = rst ? ~{NREQ{flush}} & (~full_q | grant) : '0;
  assign busy = |full_q | we_q;
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign grant_id = gid_q;
  // Slot update: flush empties, handshake (re)fills, grant drains; address 0 is swallowed.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = addr_q[i];
        sel_data = data_q[i];
      end
      if (flush) full_d[i] = 1'b0;
      else if (req_valid[i] && req_ready[i]) begin
        full_d[i] = |req_waddr[i*AW +: AW];
        addr_d[i] = req_waddr[i*AW +: AW];
        data_d[i] = req_wdata[i*DW +: DW];
      end else if (grant[i]) full_d[i] = 1'b0;
    end
  end
  // State and write port; a flush cancels the grant, so ptr and write data hold.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q <= wb_idx_t'(NREQ - 1);
      we_q <= WRITE_DISABLE;
      waddr_q <= '0;
      wdata_q <= '0;
      gid_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= (!flush && any) ? WRITE_ENABLE : WRITE_DISABLE;
      if (!flush && any) begin
        ptr_q <= idx;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        gid_q <= idx;
      end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a slot-level reference model checked every cycle
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*AW-1:0] req_waddr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic we, busy;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [2:0] grant_id;
  int checks = 0;
  int errors = 0;
  bit m_full [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int m_ptr;
  bit m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [2:0] m_gid;
  logic [2:0] gids [$];
  logic [AW-1:0] addrs [$];
  logic [5:0] we_seq;

  regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_ptr = N - 1;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_gid = '0;
  endtask

  function automatic int m_winner();
    for (int k = 1; k <= N; k++)
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input int a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_waddr[i*AW +: AW] = AW'(a);
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, '0);
  endtask

  // Compare DUT against the model mid-cycle, then advance the model by one edge.
  task automatic cycle();
    int w;
    bit b;
    logic [N-1:0] rdy;
    @(negedge clk);
    w = m_winner();
    b = m_we;
    for (int i = 0; i < N; i++) begin
      rdy[i] = rst && !flush && (!m_full[i] || i == w);
      b = b | m_full[i];
    end
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("we", 64'(we), 64'(m_we));
    chk("waddr", 64'(waddr), 64'(m_waddr));
    chk("wdata", 64'(wdata), 64'(m_wdata));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("busy", 64'(busy), 64'(b));
    if (rst) begin
      if (flush) begin
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_we = 1'b0;
      end else begin
        m_we = w >= 0;
        if (w >= 0) begin
          m_waddr = m_addr[w];
          m_wdata = m_data[w];
          m_gid = 3'(w);
          m_ptr = w;
          m_full[w] = 1'b0;
        end
        for (int i = 0; i < N; i++)
          if (req_valid[i] && rdy[i]) begin
            m_full[i] = req_waddr[i*AW +: AW] != '0;
            m_addr[i] = req_waddr[i*AW +: AW];
            m_data[i] = req_wdata[i*DW +: DW];
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    // single write from source 0
    set_req(0, 1'b1, 5, 32'h1111_1111);
    cycle();
    clear_reqs();
    cycle();
    chk("t1_we", 64'(we), 64'd1);
    chk("t1_waddr", 64'(waddr), 64'd5);
    chk("t1_wdata", 64'(wdata), 64'h1111_1111);
    chk("t1_gid", 64'(grant_id), 64'd0);
    cycle();
    chk("t1_we_off", 64'(we), 64'd0);
    // flush with slots 0 and 2 full; ptr must stay at 0
    set_req(0, 1'b1, 4, 32'h44);
    set_req(2, 1'b1, 6, 32'h66);
    cycle();
    clear_reqs();
    flush = 1'b1;
    set_req(1, 1'b1, 9, 32'h99);
    #1;
    chk("t4_flush_ready", 64'(req_ready), 64'd0);
    cycle();
    flush = 1'b0;
    clear_reqs();
    chk("t4_we", 64'(we), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    set_req(0, 1'b1, 4, 32'h44);
    set_req(2, 1'b1, 6, 32'h66);
    cycle();
    clear_reqs();
    cycle();
    chk("t4_first_gid", 64'(grant_id), 64'd2);
    chk("t4_first_addr", 64'(waddr), 64'd6);
    cycle();
    chk("t4_second_gid", 64'(grant_id), 64'd0);
    chk("t4_second_addr", 64'(waddr), 64'd4);
    cycle();
    // address 0 is swallowed
    set_req(1, 1'b1, 0, 32'hDEAD_BEEF);
    cycle();
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t3_we", 64'(we), 64'd0);
      chk("t3_busy", 64'(busy), 64'd0);
    end
    // three sources streaming; ptr is 0 here so source 1 leads
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 32'hA000_0000 | (i << 8) | c);
      cycle();
      if (we) gids.push_back(grant_id);
    end
    clear_reqs();
    chk("t2_count", 64'(gids.size()), 64'd7);
    if (gids.size() >= 6) begin
      chk("t2_g0", 64'(gids[0]), 64'd1);
      chk("t2_g1", 64'(gids[1]), 64'd2);
      chk("t2_g2", 64'(gids[2]), 64'd0);
      chk("t2_g3", 64'(gids[3]), 64'd1);
      chk("t2_g4", 64'(gids[4]), 64'd2);
      chk("t2_g5", 64'(gids[5]), 64'd0);
    end
    for (int c = 0; c < 4; c++) cycle();
    // source 2 back-to-back, order preserved
    we_seq = '0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) set_req(2, 1'b1, 7 + c, 32'h7000 + c);
      else clear_reqs();
      cycle();
      we_seq = {we_seq[4:0], we};
      if (we) addrs.push_back(waddr);
    end
    chk("t6_we_seq", 64'(we_seq), 64'b011100);
    chk("t6_count", 64'(addrs.size()), 64'd3);
    if (addrs.size() == 3) begin
      chk("t6_a0", 64'(addrs[0]), 64'd7);
      chk("t6_a1", 64'(addrs[1]), 64'd8);
      chk("t6_a2", 64'(addrs[2]), 64'd9);
    end
    // asynchronous reset mid-cycle while writing with two slots full
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 10 + i, 32'hB0 + i);
    cycle();
    clear_reqs();
    cycle();
    chk("t5_we_pre", 64'(we), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_we", 64'(we), 64'd0);
    chk("t5_waddr", 64'(waddr), 64'd0);
    chk("t5_wdata", 64'(wdata), 64'd0);
    chk("t5_gid", 64'(grant_id), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 13 + i, 32'hC0 + i);
    cycle();
    clear_reqs();
    cycle();
    chk("t5_first_gid", 64'(grant_id), 64'd0);
    chk("t5_first_addr", 64'(waddr), 64'd13);
    for (int c = 0; c < 4; c++) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
